forward_ctrl: RTL and testbench

Parametrised operand-forwarding and hazard unit for the in-order pipeline. It sits beside the decode stage and selects each source operand from EXE, MEM, WB or the register file. It detects load-use and long-latency (multi-cycle unit) hazards and raises a stall for them. A per-register scoreboard tracks outstanding multi-cycle writes, and a saturating counter records stall cycles for performance analysis.

---
 rtl/forward_ctrl_if.sv | 42 ++++
 rtl/forward_ctrl.sv | 96 +++++++++
 tb/tb_forward_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/forward_ctrl_if.sv
// Decode-side operand/hazard bundle between the pipeline (master) and forward_ctrl (slave).
// Carries register addresses, stage results, multi-cycle issue/done events, and the forwarded operands and stall signals.
interface forward_ctrl_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int CNTW = 16
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   addr1DEC, addr2DEC;
    logic            use1DEC, use2DEC;
    logic [XLEN-1:0] rs1DEC, rs2DEC;
    logic [AW-1:0]   rdEXE, rdMEM, rdWB;
    logic            WregEXE, WregMEM, WregWB;
    logic [XLEN-1:0] resultEXE, resultMEM, resultWB;
    logic            loadEXE;
    logic            mcIssue;
    logic [AW-1:0]   mcIssueRd;
    logic            mcDone;
    logic [AW-1:0]   mcDoneRd;
    logic [XLEN-1:0] rs1F, rs2F;
    logic [1:0]      fwdSel1, fwdSel2;
    logic            stall;
    logic [CNTW-1:0] stallCount;
    logic            sbErr;

    modport master (
        output addr1DEC, addr2DEC, use1DEC, use2DEC, rs1DEC, rs2DEC,
        output rdEXE, rdMEM, rdWB, WregEXE, WregMEM, WregWB,
        output resultEXE, resultMEM, resultWB, loadEXE,
        output mcIssue, mcIssueRd, mcDone, mcDoneRd,
        input  rs1F, rs2F, fwdSel1, fwdSel2, stall, stallCount, sbErr
    );

    modport slave (
        input  addr1DEC, addr2DEC, use1DEC, use2DEC, rs1DEC, rs2DEC,
        input  rdEXE, rdMEM, rdWB, WregEXE, WregMEM, WregWB,
        input  resultEXE, resultMEM, resultWB, loadEXE,
        input  mcIssue, mcIssueRd, mcDone, mcDoneRd,
        output rs1F, rs2F, fwdSel1, fwdSel2, stall, stallCount, sbErr
    );
endinterface

// File: rtl/forward_ctrl.sv
// Operand forwarding (EXE > MEM > WB > regfile) plus load-use and multi-cycle scoreboard stall detection.
// Forwarding and stall are zero-latency combinational; scoreboard, stall counter and sbErr update on the clock edge.
// Backpressure: stall holds DEC/IF and bubbles EXE; no internal buffering.
module forward_ctrl #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int CNTW = 16
) (
    input  logic          clock,
    input  logic          nReset,
    forward_ctrl_if.slave fc
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0] pending, pending_nxt;
    logic [CNTW-1:0] stall_cnt;
    logic            sb_err;
    logic [1:0]      sel1, sel2;
    logic            haz1, haz2, stall_c, issue_err;

    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] a,
        input logic we, input logic [AW-1:0] re,
        input logic wm, input logic [AW-1:0] rm,
        input logic ww, input logic [AW-1:0] rw
    );
        fwd_sel = 2'd0;
        if (a != '0) begin
            if (we && re == a)      fwd_sel = 2'd1;
            else if (wm && rm == a) fwd_sel = 2'd2;
            else if (ww && rw == a) fwd_sel = 2'd3;
        end
    endfunction

    always_comb begin
        sel1 = fwd_sel(fc.addr1DEC, fc.WregEXE, fc.rdEXE, fc.WregMEM, fc.rdMEM, fc.WregWB, fc.rdWB);
        sel2 = fwd_sel(fc.addr2DEC, fc.WregEXE, fc.rdEXE, fc.WregMEM, fc.rdMEM, fc.WregWB, fc.rdWB);
    end

    always_comb begin
        case (sel1)
            2'd1:    fc.rs1F = fc.resultEXE;
            2'd2:    fc.rs1F = fc.resultMEM;
            2'd3:    fc.rs1F = fc.resultWB;
            default: fc.rs1F = fc.rs1DEC;
        endcase
        case (sel2)
            2'd1:    fc.rs2F = fc.resultEXE;
            2'd2:    fc.rs2F = fc.resultMEM;
            2'd3:    fc.rs2F = fc.resultWB;
            default: fc.rs2F = fc.rs2DEC;
        endcase
    end

    // A completing op clears its own hazard because its value arrives on the WB forward path this cycle.
    assign haz1 = fc.use1DEC && (fc.addr1DEC != '0) &&
                  ((fc.loadEXE && fc.WregEXE && fc.rdEXE == fc.addr1DEC) ||
                   (pending[fc.addr1DEC] && !(fc.mcDone && fc.mcDoneRd == fc.addr1DEC)));
    assign haz2 = fc.use2DEC && (fc.addr2DEC != '0) &&
                  ((fc.loadEXE && fc.WregEXE && fc.rdEXE == fc.addr2DEC) ||
                   (pending[fc.addr2DEC] && !(fc.mcDone && fc.mcDoneRd == fc.addr2DEC)));
    assign stall_c = haz1 || haz2;

    assign issue_err = fc.mcIssue && (fc.mcIssueRd != '0) && pending[fc.mcIssueRd] &&
                       !(fc.mcDone && fc.mcDoneRd == fc.mcIssueRd);

    // Set after clear so a same-cycle reissue keeps the register pending.
    always_comb begin
        pending_nxt = pending;
        if (fc.mcDone)
            pending_nxt[fc.mcDoneRd] = 1'b0;
        if (fc.mcIssue && fc.mcIssueRd != '0)
            pending_nxt[fc.mcIssueRd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!nReset) begin
            pending   <= '0;
            stall_cnt <= '0;
            sb_err    <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (stall_c && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNTW'(1);
            if (issue_err)
                sb_err <= 1'b1;
        end
    end

    assign fc.fwdSel1    = sel1;
    assign fc.fwdSel2    = sel2;
    assign fc.stall      = stall_c;
    assign fc.stallCount = stall_cnt;
    assign fc.sbErr      = sb_err;
endmodule

// File: tb/tb_forward_ctrl.sv
// Directed and randomized checks of forward_ctrl against a queue/array-level reference model.
module tb_forward_ctrl;
    logic clock = 1'b0;
    logic nReset = 1'b0;
    always #5 clock = ~clock;

    forward_ctrl_if #(.XLEN(32), .NREG(32), .CNTW(16)) fi ();
    forward_ctrl_if #(.XLEN(32), .NREG(32), .CNTW(4))  fi4 ();

    forward_ctrl #(.XLEN(32), .NREG(32), .CNTW(16)) dut  (.clock(clock), .nReset(nReset), .fc(fi.slave));
    forward_ctrl #(.XLEN(32), .NREG(32), .CNTW(4))  dut4 (.clock(clock), .nReset(nReset), .fc(fi4.slave));

    assign fi4.addr1DEC = fi.addr1DEC;   assign fi4.addr2DEC = fi.addr2DEC;
    assign fi4.use1DEC = fi.use1DEC;     assign fi4.use2DEC = fi.use2DEC;
    assign fi4.rs1DEC = fi.rs1DEC;       assign fi4.rs2DEC = fi.rs2DEC;
    assign fi4.rdEXE = fi.rdEXE;         assign fi4.rdMEM = fi.rdMEM;       assign fi4.rdWB = fi.rdWB;
    assign fi4.WregEXE = fi.WregEXE;     assign fi4.WregMEM = fi.WregMEM;   assign fi4.WregWB = fi.WregWB;
    assign fi4.resultEXE = fi.resultEXE; assign fi4.resultMEM = fi.resultMEM; assign fi4.resultWB = fi.resultWB;
    assign fi4.loadEXE = fi.loadEXE;
    assign fi4.mcIssue = fi.mcIssue;     assign fi4.mcIssueRd = fi.mcIssueRd;
    assign fi4.mcDone = fi.mcDone;       assign fi4.mcDoneRd = fi.mcDoneRd;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit m_pend [32];
    int m_cnt  = 0;
    int m_cnt4 = 0;
    bit m_err  = 0;

    function automatic void m_fwd(input int n, output logic [31:0] val, output logic [1:0] sel);
        int a;
        bit w [3];
        int rd [3];
        logic [31:0] res [3];
        a = (n == 1) ? int'(fi.addr1DEC) : int'(fi.addr2DEC);
        w[0] = fi.WregEXE; rd[0] = int'(fi.rdEXE); res[0] = fi.resultEXE;
        w[1] = fi.WregMEM; rd[1] = int'(fi.rdMEM); res[1] = fi.resultMEM;
        w[2] = fi.WregWB;  rd[2] = int'(fi.rdWB);  res[2] = fi.resultWB;
        val = (n == 1) ? fi.rs1DEC : fi.rs2DEC;
        sel = 2'd0;
        for (int s = 2; s >= 0; s--)
            if (a != 0 && w[s] && rd[s] == a) begin
                val = res[s];
                sel = 2'(s + 1);
            end
    endfunction

    function automatic bit m_stall();
        bit st = 0;
        for (int n = 1; n <= 2; n++) begin
            int a;
            bit u;
            a = (n == 1) ? int'(fi.addr1DEC) : int'(fi.addr2DEC);
            u = (n == 1) ? fi.use1DEC : fi.use2DEC;
            if (u && a != 0) begin
                if (fi.loadEXE && fi.WregEXE && int'(fi.rdEXE) == a) st = 1;
                if (m_pend[a] && !(fi.mcDone && int'(fi.mcDoneRd) == a)) st = 1;
            end
        end
        return st;
    endfunction

    always @(posedge clock) begin
        bit st;
        if (!nReset) begin
            foreach (m_pend[i]) m_pend[i] <= 0;
            m_cnt <= 0; m_cnt4 <= 0; m_err <= 0;
        end else begin
            st = m_stall();
            if (st) begin
                m_cnt  <= (m_cnt  + 1 > 65535) ? 65535 : m_cnt + 1;
                m_cnt4 <= (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
            end
            if (fi.mcIssue && fi.mcIssueRd != 0 && m_pend[fi.mcIssueRd] &&
                !(fi.mcDone && fi.mcDoneRd == fi.mcIssueRd))
                m_err <= 1;
            if (fi.mcDone) m_pend[fi.mcDoneRd] <= 0;
            if (fi.mcIssue && fi.mcIssueRd != 0) m_pend[fi.mcIssueRd] <= 1;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        fi.addr1DEC = 0; fi.addr2DEC = 0; fi.use1DEC = 0; fi.use2DEC = 0;
        fi.rs1DEC = 0; fi.rs2DEC = 0;
        fi.rdEXE = 0; fi.rdMEM = 0; fi.rdWB = 0;
        fi.WregEXE = 0; fi.WregMEM = 0; fi.WregWB = 0;
        fi.resultEXE = 0; fi.resultMEM = 0; fi.resultWB = 0;
        fi.loadEXE = 0; fi.mcIssue = 0; fi.mcIssueRd = 0; fi.mcDone = 0; fi.mcDoneRd = 0;
    endtask

    task automatic do_reset();
        idle();
        nReset = 0;
        cyc();
        nReset = 1;
    endtask

    task automatic test_reset();
        idle();
        nReset = 0;
        repeat (3) cyc();
        fi.rs1DEC = 32'h1111; fi.addr1DEC = 5; fi.use1DEC = 1;
        nReset = 1;
        @(negedge clock);
        n_cmp++; if (fi.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%0b exp=0", fi.stall); end
        n_cmp++; if (fi.stallCount !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", fi.stallCount); end
        n_cmp++; if (fi.sbErr !== 1'b0) begin n_err++; $display("FAIL reset_sberr got=%0b exp=0", fi.sbErr); end
        n_cmp++; if (fi.rs1F !== 32'h1111 || fi.fwdSel1 !== 2'd0) begin n_err++; $display("FAIL reset_fwd got=%h/%0d exp=1111/0", fi.rs1F, fi.fwdSel1); end
        cyc();
    endtask

    task automatic test_priority();
        logic [31:0] ev [4];
        logic [1:0]  es [4];
        ev[0] = 32'hA; ev[1] = 32'hB; ev[2] = 32'hC; ev[3] = 32'hDEAD_0001;
        es[0] = 2'd1;  es[1] = 2'd2;  es[2] = 2'd3;  es[3] = 2'd0;
        do_reset();
        fi.addr1DEC = 5; fi.use1DEC = 1; fi.rs1DEC = 32'hDEAD_0001;
        fi.rdEXE = 5; fi.rdMEM = 5; fi.rdWB = 5;
        fi.resultEXE = 32'hA; fi.resultMEM = 32'hB; fi.resultWB = 32'hC;
        fi.WregEXE = 1; fi.WregMEM = 1; fi.WregWB = 1;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) fi.WregEXE = 0;
            if (k == 2) fi.WregMEM = 0;
            if (k == 3) fi.WregWB = 0;
            #2;
            n_cmp++; if (fi.rs1F !== ev[k]) begin n_err++; $display("FAIL prio_val[%0d] got=%h exp=%h", k, fi.rs1F, ev[k]); end
            n_cmp++; if (fi.fwdSel1 !== es[k]) begin n_err++; $display("FAIL prio_sel[%0d] got=%0d exp=%0d", k, fi.fwdSel1, es[k]); end
        end
        cyc();
    endtask

    task automatic test_x0();
        do_reset();
        fi.rdEXE = 0; fi.rdMEM = 0; fi.rdWB = 0;
        fi.WregEXE = 1; fi.WregMEM = 1; fi.WregWB = 1; fi.loadEXE = 1;
        fi.resultEXE = 32'hFFFF_FFFF; fi.resultMEM = 32'hFFFF_FFFF; fi.resultWB = 32'hFFFF_FFFF;
        fi.use1DEC = 1; fi.use2DEC = 1;
        fi.mcIssue = 1; fi.mcIssueRd = 0;
        @(negedge clock);
        n_cmp++; if (fi.rs1F !== 32'd0 || fi.rs2F !== 32'd0) begin n_err++; $display("FAIL x0_fwd got=%h/%h exp=0/0", fi.rs1F, fi.rs2F); end
        n_cmp++; if (fi.stall !== 1'b0) begin n_err++; $display("FAIL x0_stall got=%0b exp=0", fi.stall); end
        cyc();
        fi.mcIssue = 0; fi.mcIssue = 1;
        cyc();
        fi.mcIssue = 0;
        @(negedge clock);
        n_cmp++; if (fi.sbErr !== 1'b0 || fi.stall !== 1'b0) begin n_err++; $display("FAIL x0_sb got=%0b/%0b exp=0/0", fi.sbErr, fi.stall); end
        cyc();
    endtask

    task automatic test_load_use();
        do_reset();
        fi.loadEXE = 1; fi.WregEXE = 1; fi.rdEXE = 7; fi.addr2DEC = 7; fi.use2DEC = 1;
        @(negedge clock);
        n_cmp++; if (fi.stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got=%0b exp=1", fi.stall); end
        cyc();
        fi.loadEXE = 0; fi.WregEXE = 0; fi.rdEXE = 0;
        fi.WregMEM = 1; fi.rdMEM = 7; fi.resultMEM = 32'h1234;
        @(negedge clock);
        n_cmp++; if (fi.stall !== 1'b0) begin n_err++; $display("FAIL lu_release got=%0b exp=0", fi.stall); end
        n_cmp++; if (fi.rs2F !== 32'h1234 || fi.fwdSel2 !== 2'd2) begin n_err++; $display("FAIL lu_fwd got=%h/%0d exp=1234/2", fi.rs2F, fi.fwdSel2); end
        n_cmp++; if (fi.stallCount !== 16'd1) begin n_err++; $display("FAIL lu_cnt got=%0d exp=1", fi.stallCount); end
        cyc();
        idle();
        fi.loadEXE = 1; fi.WregEXE = 1; fi.rdEXE = 7; fi.addr2DEC = 7; fi.use2DEC = 0;
        @(negedge clock);
        n_cmp++; if (fi.stall !== 1'b0) begin n_err++; $display("FAIL lu_unused got=%0b exp=0", fi.stall); end
        cyc();
    endtask

    task automatic test_scoreboard();
        do_reset();
        fi.mcIssue = 1; fi.mcIssueRd = 9;
        cyc();
        fi.mcIssue = 0; fi.addr1DEC = 9; fi.use1DEC = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            n_cmp++; if (fi.stall !== 1'b1) begin n_err++; $display("FAIL sb_stall[t+%0d] got=%0b exp=1", k, fi.stall); end
            cyc();
        end
        fi.mcDone = 1; fi.mcDoneRd = 9; fi.WregWB = 1; fi.rdWB = 9; fi.resultWB = 32'h55;
        @(negedge clock);
        n_cmp++; if (fi.stall !== 1'b0) begin n_err++; $display("FAIL sb_done_stall got=%0b exp=0", fi.stall); end
        n_cmp++; if (fi.rs1F !== 32'h55 || fi.fwdSel1 !== 2'd3) begin n_err++; $display("FAIL sb_done_fwd got=%h/%0d exp=55/3", fi.rs1F, fi.fwdSel1); end
        n_cmp++; if (fi.stallCount !== 16'd3) begin n_err++; $display("FAIL sb_cnt got=%0d exp=3", fi.stallCount); end
        cyc();
        fi.mcDone = 0; fi.WregWB = 0;
        @(negedge clock);
        n_cmp++; if (fi.stall !== 1'b0) begin n_err++; $display("FAIL sb_cleared got=%0b exp=0", fi.stall); end
        cyc();
    endtask

    task automatic test_simul_err();
        do_reset();
        fi.mcIssue = 1; fi.mcIssueRd = 9;
        cyc();
        fi.mcDone = 1; fi.mcDoneRd = 9;
        cyc();
        idle();
        fi.addr1DEC = 9; fi.use1DEC = 1;
        @(negedge clock);
        n_cmp++; if (fi.stall !== 1'b1) begin n_err++; $display("FAIL simul_pending got=%0b exp=1", fi.stall); end
        n_cmp++; if (fi.sbErr !== 1'b0) begin n_err++; $display("FAIL simul_noerr got=%0b exp=0", fi.sbErr); end
        cyc();
        idle();
        fi.mcDone = 1; fi.mcDoneRd = 12;
        cyc();
        fi.mcDone = 0;
        @(negedge clock);
        n_cmp++; if (fi.sbErr !== 1'b0) begin n_err++; $display("FAIL spurious_done got=%0b exp=0", fi.sbErr); end
        cyc();
        fi.mcIssue = 1; fi.mcIssueRd = 9;
        cyc();
        idle();
        repeat (3) cyc();
        @(negedge clock);
        n_cmp++; if (fi.sbErr !== 1'b1) begin n_err++; $display("FAIL sberr_sticky got=%0b exp=1", fi.sbErr); end
        cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        fi.loadEXE = 1; fi.WregEXE = 1; fi.rdEXE = 6; fi.addr1DEC = 6; fi.use1DEC = 1;
        repeat (20) @(posedge clock);
        #1;
        idle();
        @(negedge clock);
        n_cmp++; if (fi.stallCount !== 16'd20) begin n_err++; $display("FAIL cnt20 got=%0d exp=20", fi.stallCount); end
        n_cmp++; if (fi4.stallCount !== 4'd15) begin n_err++; $display("FAIL cnt_sat got=%0d exp=15", fi4.stallCount); end
        cyc();
        fi.mcIssue = 1; fi.mcIssueRd = 3; cyc();
        fi.mcIssueRd = 4; cyc();
        fi.mcIssueRd = 3; cyc();
        idle();
        fi.addr1DEC = 3; fi.use1DEC = 1;
        @(negedge clock);
        n_cmp++; if (fi.sbErr !== 1'b1 || fi.stall !== 1'b1) begin n_err++; $display("FAIL pre_reset got=%0b/%0b exp=1/1", fi.sbErr, fi.stall); end
        nReset = 0;
        fi.mcIssue = 1; fi.mcIssueRd = 5;
        cyc();
        nReset = 1; fi.mcIssue = 0;
        fi.addr2DEC = 5; fi.use2DEC = 1;
        @(negedge clock);
        n_cmp++; if (fi.stall !== 1'b0) begin n_err++; $display("FAIL post_reset_stall got=%0b exp=0", fi.stall); end
        n_cmp++; if (fi.stallCount !== 16'd0 || fi4.stallCount !== 4'd0) begin n_err++; $display("FAIL post_reset_cnt got=%0d/%0d exp=0/0", fi.stallCount, fi4.stallCount); end
        n_cmp++; if (fi.sbErr !== 1'b0) begin n_err++; $display("FAIL post_reset_sberr got=%0b exp=0", fi.sbErr); end
        cyc();
    endtask

    task automatic test_random();
        logic [31:0] v1, v2;
        logic [1:0]  s1, s2;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            fi.addr1DEC = 5'($urandom_range(0, 7)); fi.addr2DEC = 5'($urandom_range(0, 7));
            fi.use1DEC = 1'($urandom); fi.use2DEC = 1'($urandom);
            fi.rs1DEC = $urandom; fi.rs2DEC = $urandom;
            fi.rdEXE = 5'($urandom_range(0, 7)); fi.rdMEM = 5'($urandom_range(0, 7)); fi.rdWB = 5'($urandom_range(0, 7));
            fi.WregEXE = 1'($urandom); fi.WregMEM = 1'($urandom); fi.WregWB = 1'($urandom);
            fi.resultEXE = $urandom; fi.resultMEM = $urandom; fi.resultWB = $urandom;
            fi.loadEXE = ($urandom_range(0, 3) == 0);
            fi.mcIssue = ($urandom_range(0, 4) == 0); fi.mcIssueRd = 5'($urandom_range(0, 7));
            fi.mcDone = ($urandom_range(0, 3) == 0);  fi.mcDoneRd = 5'($urandom_range(0, 7));
            nReset = ($urandom_range(0, 99) != 0);
            @(negedge clock);
            m_fwd(1, v1, s1);
            m_fwd(2, v2, s2);
            n_cmp++; if (fi.rs1F !== v1 || fi.fwdSel1 !== s1) begin n_err++; $display("FAIL rnd_fwd1[%0d] got=%h/%0d exp=%h/%0d", k, fi.rs1F, fi.fwdSel1, v1, s1); end
            n_cmp++; if (fi.rs2F !== v2 || fi.fwdSel2 !== s2) begin n_err++; $display("FAIL rnd_fwd2[%0d] got=%h/%0d exp=%h/%0d", k, fi.rs2F, fi.fwdSel2, v2, s2); end
            n_cmp++; if (fi.stall !== m_stall()) begin n_err++; $display("FAIL rnd_stall[%0d] got=%0b exp=%0b", k, fi.stall, m_stall()); end
            n_cmp++; if (int'(fi.stallCount) != m_cnt || int'(fi4.stallCount) != m_cnt4) begin n_err++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", k, fi.stallCount, fi4.stallCount, m_cnt, m_cnt4); end
            n_cmp++; if (fi.sbErr !== m_err) begin n_err++; $display("FAIL rnd_sberr[%0d] got=%0b exp=%0b", k, fi.sbErr, m_err); end
            cyc();
        end
        nReset = 1;
    endtask

    initial begin
        idle();
        test_reset();
        test_priority();
        test_x0();
        test_load_use();
        test_scoreboard();
        test_simul_err();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
